exc_ctrl: RTL
=============

EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 PC_M  in  32  PC of instruction in M stage.
REQ-004 ExcGot_M  in  1  M-stage instruction carries an exception.
REQ-005 ExcCode_M  in  5  exception code of M-stage instruction: 4 AdEL, 5 AdES, 10 RI, 12 Ov.
REQ-006 BD_M  in  1  M-stage instruction sits in a branch delay slot.
REQ-007 Eret_M  in  1  M-stage instruction is eret.
REQ-008 CP0We  in  1  mtc0 write enable (M stage).
REQ-009 CP0Addr  in  5  CP0 register number for mtc0/mfc0.
REQ-010 CP0WD  in  32  mtc0 write data.
REQ-011 HWInt  in  6  external interrupt lines, level-sensitive.
REQ-012 CP0RD  out  32  mfc0 read data, combinational.
REQ-013 Req  out  1  flush all stages and redirect fetch.
REQ-014 NPC  out  32  redirect target, valid while Req=1.
REQ-015 EPC  out  32  current EPC value.

Function
REQ-016 Registers SHALL be SR(12), Cause(13), EPC(14), PRId(15); other addresses SHALL read 0.
REQ-017 SR fields: IM=SR[15:10], EXL=SR[1], IE=SR[0]; other SR bits SHALL read 0.
REQ-018 Cause fields: BD=[31], IP=[15:10], ExcCode=[6:2]; IP SHALL be loaded from HWInt every cycle; other bits read 0.
REQ-019 PRId SHALL be constant 32'h0000_7A01 and ignore writes.
REQ-020 IntReq = |(HWInt & IM) & IE & !EXL; ExcReq = ExcGot_M & !EXL.
REQ-021 Priority, same cycle: IntReq > ExcReq > Eret_M > mtc0.
REQ-022 On IntReq or ExcReq in state RUN: Req=1 combinationally, NPC=32'h0000_4180; at next edge EXL<=1, ExcCode<=0 (int) or ExcCode_M, EPC<=PC_M[31:2]<<2, BD per REQ-031; mtc0 that cycle SHALL be dropped.
REQ-023 On Eret_M in RUN with no higher event: Req=1, NPC=EPC; at next edge EXL<=0.
REQ-024 mtc0 in RUN with no event: write SR (IM, EXL, IE only) or EPC (low 2 bits forced 0); Cause and PRId writes ignored.
REQ-025 FSM states RUN and FLUSH; any cycle with Req=1 SHALL move to FLUSH; FLUSH SHALL last exactly one cycle then return to RUN.
REQ-026 In FLUSH: Req=0, ExcGot_M, Eret_M, CP0We and IntReq SHALL be ignored (M holds a nullified bubble).
REQ-027 CP0RD SHALL return the pre-edge register value; a mtc0 to the same address is visible the following cycle.
REQ-028 While EXL=1, ExcGot_M SHALL be ignored (no nested exception); Eret_M still honoured.
REQ-029 Latency: Req asserted in the same cycle as the M-stage event; register effects one edge later.

Reset
REQ-030 Asynchronous reset SHALL force state RUN, SR=0, Cause=0, EPC=0, Req=0, NPC=0; PRId unaffected.

Configuration
REQ-031 Macro EXC_BD_EN: when defined, on entry with BD_M=1 EPC<=PC_M-4 and Cause.BD<=1, else EPC<=PC_M and BD<=0; when undefined, BD_M SHALL be ignored, EPC<=PC_M and Cause.BD SHALL read 0.

Verification
REQ-032 Reset mid-FLUSH -> next cycle state RUN, Req=0, SR=0, EPC=0.
REQ-033 ExcGot_M=1, ExcCode_M=12, PC_M=0x3010, SR=0 -> Req=1, NPC=0x4180; next cycle EXL=1, Cause[6:2]=12, EPC=0x3010, Req=0.
REQ-034 SR=0x0000_0401, HWInt=6'b000001, same cycle ExcGot_M=1 code 4 -> interrupt wins: Cause[6:2]=0, Cause[10]=1, EPC=PC_M.
REQ-035 EXL=1, EPC=0x3020, Eret_M=1 -> Req=1, NPC=0x3020; next cycle EXL=0; Eret_M held in FLUSH cycle -> Req=0.
REQ-036 With EXC_BD_EN, ExcGot_M=1 code 10, BD_M=1, PC_M=0x3008 -> EPC=0x3004, Cause[31]=1; without macro -> EPC=0x3008, Cause[31]=0.
REQ-037 mtc0 CP0Addr=14 data 0x3007 -> next cycle CP0RD(14)=0x3004; mtc0 CP0Addr=15 -> PRId stays 0x0000_7A01.

Source files
------------

// File: rtl/exc_ctrl.sv
// CP0 exception controller: SR/Cause/EPC/PRId, interrupt and exception entry, eret return.
// Optional macro EXC_BD_EN enables branch-delay-slot aware EPC and Cause.BD.
module exc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_M,
  input  logic        ExcGot_M,
  input  logic [4:0]  ExcCode_M,
  input  logic        BD_M,
  input  logic        Eret_M,
  input  logic        CP0We,
  input  logic [4:0]  CP0Addr,
  input  logic [31:0] CP0WD,
  input  logic [5:0]  HWInt,
  output logic [31:0] CP0RD,
  output logic        Req,
  output logic [31:0] NPC,
  output logic [31:0] EPC
);

  localparam logic [31:0] PRID_VALUE  = 32'h0000_7A01;
  localparam logic [31:0] HANDLER_PC  = 32'h0000_4180;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t      state, next_state;
  logic [5:0]  sr_im;
  logic        sr_exl, sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc_reg;

  logic        int_req, exc_req, take_exc, take_eret, do_write;
  logic [31:0] entry_pc;
  logic        entry_bd;
  logic [31:0] sr_val, cause_val;

  // Entry PC selection; the delay-slot case points EPC back at the branch.
`ifdef EXC_BD_EN
  assign entry_pc = BD_M ? (PC_M - 32'd4) : PC_M;
  assign entry_bd = BD_M;
  logic unused_ok;
  assign unused_ok = ^entry_pc[1:0];
`else
  assign entry_pc = PC_M;
  assign entry_bd = 1'b0;
  logic unused_ok;
  assign unused_ok = ^{BD_M, entry_pc[1:0]};
`endif

  assign sr_val    = {16'b0, sr_im, 8'b0, sr_exl, sr_ie};
  assign cause_val = {cause_bd, 15'b0, cause_ip, 3'b0, cause_exc, 2'b0};
  assign EPC       = epc_reg;

  always_comb begin
    CP0RD = 32'b0;
    case (CP0Addr)
      5'd12:   CP0RD = sr_val;
      5'd13:   CP0RD = cause_val;
      5'd14:   CP0RD = epc_reg;
      5'd15:   CP0RD = PRID_VALUE;
      default: CP0RD = 32'b0;
    endcase
  end

  // In FLUSH the M stage holds a bubble, so every event source is masked.
  always_comb begin
    int_req    = 1'b0;
    exc_req    = 1'b0;
    take_exc   = 1'b0;
    take_eret  = 1'b0;
    do_write   = 1'b0;
    Req        = 1'b0;
    NPC        = 32'b0;
    next_state = RUN;
    if (state == RUN) begin
      int_req   = (|(HWInt & sr_im)) & sr_ie & ~sr_exl;
      exc_req   = ExcGot_M & ~sr_exl;
      take_exc  = int_req | exc_req;
      take_eret = ~take_exc & Eret_M;
      do_write  = ~take_exc & ~Eret_M & CP0We;
      if (take_exc) begin
        Req = 1'b1;
        NPC = HANDLER_PC;
      end else if (take_eret) begin
        Req = 1'b1;
        NPC = epc_reg;
      end
      next_state = Req ? FLUSH : RUN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= next_state;
  end

  // CP0 register file; IP tracks the interrupt lines every cycle regardless of state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_im     <= 6'b0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= 6'b0;
      cause_exc <= 5'b0;
      epc_reg   <= 32'b0;
    end else begin
      cause_ip <= HWInt;
      if (take_exc) begin
        sr_exl    <= 1'b1;
        cause_exc <= int_req ? 5'd0 : ExcCode_M;
        cause_bd  <= entry_bd;
        epc_reg   <= {entry_pc[31:2], 2'b00};
      end else if (take_eret) begin
        sr_exl <= 1'b0;
      end else if (do_write) begin
        if (CP0Addr == 5'd12) begin
          sr_im  <= CP0WD[15:10];
          sr_exl <= CP0WD[1];
          sr_ie  <= CP0WD[0];
        end else if (CP0Addr == 5'd14) begin
          epc_reg <= {CP0WD[31:2], 2'b00};
        end
      end
    end
  end

endmodule
